dglitch_loop_control_u54_u18: RTL

//  Digital deglitch filter in LOOP/CONTROL. It drives the i pin of the downstream

---
 rtl/dglitch_loop_control_u54_u18.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/dglitch_loop_control_u54_u18.sv
// Digital deglitch filter for the LOOP/CONTROL path. It qualifies a raw
// level with asymmetric rise/fall filter times before the level drives the
// downstream buffer input.
// Optional build macro: DGLITCH_SYNC_EN adds a 2-flop synchronizer ahead of
// the sample flop. Without it, i must already be synchronous to clk.
// FSM handshake: there is no valid/ready pair. Every rising clk edge
// consumes one sample s and produces one registered (o, busy) pair.
module dglitch_loop_control_u54_u18 #(
  parameter int RISE_CNT = 8,
  parameter int FALL_CNT = 4,
  parameter int CW       = 4
) (
  input  logic clk,
  input  logic rstb,
  input  logic CELV,
  input  logic CELG,
  input  logic SUB,
  input  logic i,
  input  logic en,
  output logic o,
  output logic busy
);

  // Reject filter counts the counter cannot represent
  if (RISE_CNT < 1 || RISE_CNT > (2**CW) - 1) begin : g_bad_rise
    $error("dglitch_loop_control_u54_u18: RISE_CNT out of range 1..2**CW-1");
  end
  if (FALL_CNT < 1 || FALL_CNT > (2**CW) - 1) begin : g_bad_fall
    $error("dglitch_loop_control_u54_u18: FALL_CNT out of range 1..2**CW-1");
  end

  localparam logic [CW-1:0] RISE_LAST = CW'(RISE_CNT - 1);
  localparam logic [CW-1:0] FALL_LAST = CW'(FALL_CNT - 1);

  typedef enum logic [1:0] {
    ST_LO      = 2'd0,
    ST_QUAL_HI = 2'd1,
    ST_HI      = 2'd2,
    ST_QUAL_LO = 2'd3
  } state_t;

  // Supply pins carry no logic; fold them so they are not left dangling
  logic w_unused_supply;
  assign w_unused_supply = ^{CELV, CELG, SUB};

  logic   w_s_d;
  logic   r_s;
  state_t r_state;
  state_t w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic   r_o;
  logic   r_busy;
  logic   w_o_nxt;
  logic   w_busy_nxt;

`ifdef DGLITCH_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-flop synchronizer ahead of the sample flop
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s_d = r_sync2;
`else
  assign w_s_d = i;
`endif

  // Sample flop; keeps running regardless of en
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_s <= 1'b0;
    end else begin
      r_s <= w_s_d;
    end
  end

  // State register: state, counter and the registered outputs move together
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= ST_LO;
      r_cnt   <= '0;
      r_o     <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_o     <= w_o_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state logic: disabled filter parks in the stable state matching o
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!en) begin
      w_state_nxt = r_o ? ST_HI : ST_LO;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_LO: begin
          if (r_s) begin
            if (RISE_CNT == 1) begin
              w_state_nxt = ST_HI;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = ST_QUAL_HI;
              w_cnt_nxt   = CW'(1);
            end
          end
        end
        ST_QUAL_HI: begin
          if (!r_s) begin
            w_state_nxt = ST_LO;
            w_cnt_nxt   = '0;
          end else if (r_cnt == RISE_LAST) begin
            w_state_nxt = ST_HI;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + CW'(1);
          end
        end
        ST_HI: begin
          if (!r_s) begin
            if (FALL_CNT == 1) begin
              w_state_nxt = ST_LO;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = ST_QUAL_LO;
              w_cnt_nxt   = CW'(1);
            end
          end
        end
        ST_QUAL_LO: begin
          if (r_s) begin
            w_state_nxt = ST_HI;
            w_cnt_nxt   = '0;
          end else if (r_cnt == FALL_LAST) begin
            w_state_nxt = ST_LO;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_LO;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output decode of the next state, so o/busy register alongside state
  always_comb begin
    w_o_nxt    = (w_state_nxt == ST_HI) || (w_state_nxt == ST_QUAL_LO);
    w_busy_nxt = (w_state_nxt == ST_QUAL_HI) || (w_state_nxt == ST_QUAL_LO);
  end

  assign o    = r_o;
  assign busy = r_busy;

endmodule
